// File: rtl/ysyx_22040127_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22040127_hazard_ctrl
// Description : Hazard controller for a 5-stage in-order pipeline whose
//               branches resolve in ID. Tracks the writers in EX/MEM/WB,
//               selects forwarding sources, detects load-use and branch
//               stalls, squashes IF on taken branches, counts stalls/flushes.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22040127_hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_reg_wen,
  input  logic        id_memread,
  input  logic        id_branch,
  input  logic        id_branch_taken,
  input  logic        pipe_adv,
  output logic        id_stall,
  output logic [1:0]  fwd_sel1,
  output logic [1:0]  fwd_sel2,
  output logic        if_flush,
  output logic [1:0]  ctrl_state,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wen;
    logic       memread;
  } sb_entry_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01,
    ST_FLUSH = 2'b10
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  sb_entry_t ex_e;
  sb_entry_t mem_e;
  // Once a load reaches WB its data is available for forwarding, so the
  // memread flag has no further use and is not carried into this stage.
  logic       wb_valid;
  logic [4:0] wb_rd;
  logic       wb_wen;
  state_t     state;

  // A stage matches a source when it will write that (non-x0) register.
  function automatic logic match(input logic valid, input logic wen,
                                 input logic [4:0] rd, input logic [4:0] rs,
                                 input logic use_rs);
    return valid & wen & (rd != 5'd0) & (rd == rs) & use_rs;
  endfunction

  // Forward from the youngest matching writer; ID bubbles read the regfile.
  function automatic logic [1:0] pick(input logic v, input logic m_ex,
                                      input logic m_mem, input logic m_wb);
    if (!v)        return FWD_RF;
    else if (m_ex) return FWD_EX;
    else if (m_mem) return FWD_MEM;
    else if (m_wb) return FWD_WB;
    else           return FWD_RF;
  endfunction

  logic ex_m1, ex_m2, mem_m1, mem_m2, wb_m1, wb_m2;
  logic load_use, branch_dep;

  assign ex_m1  = match(ex_e.valid, ex_e.wen, ex_e.rd, id_rs1, id_use_rs1);
  assign ex_m2  = match(ex_e.valid, ex_e.wen, ex_e.rd, id_rs2, id_use_rs2);
  assign mem_m1 = match(mem_e.valid, mem_e.wen, mem_e.rd, id_rs1, id_use_rs1);
  assign mem_m2 = match(mem_e.valid, mem_e.wen, mem_e.rd, id_rs2, id_use_rs2);
  assign wb_m1  = match(wb_valid, wb_wen, wb_rd, id_rs1, id_use_rs1);
  assign wb_m2  = match(wb_valid, wb_wen, wb_rd, id_rs2, id_use_rs2);

  assign fwd_sel1 = pick(id_valid, ex_m1, mem_m1, wb_m1);
  assign fwd_sel2 = pick(id_valid, ex_m2, mem_m2, wb_m2);

  // Load data is not ready until the end of MEM, so an EX load must stall.
  assign load_use   = id_valid & (ex_m1 | ex_m2) & ex_e.memread;
  // Branches compare in ID: any EX producer, or a load still in MEM, is late.
  assign branch_dep = id_valid & id_branch &
                      ((ex_m1 | ex_m2) | ((mem_m1 | mem_m2) & mem_e.memread));
  assign id_stall   = load_use | branch_dep;

  // Redirect only once operands are ready and the pipe actually moves.
  assign if_flush = id_valid & id_branch & id_branch_taken & ~id_stall & pipe_adv;

  assign ctrl_state = state;

  // Scoreboard shift: EX takes the ID instruction or a bubble on a stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_e     <= '0;
      mem_e    <= '0;
      wb_valid <= 1'b0;
      wb_rd    <= 5'd0;
      wb_wen   <= 1'b0;
    end else if (pipe_adv) begin
      wb_valid <= mem_e.valid;
      wb_rd    <= mem_e.rd;
      wb_wen   <= mem_e.wen;
      mem_e    <= ex_e;
      if (id_stall) ex_e <= '0;
      else          ex_e <= {id_valid, id_rd, id_reg_wen, id_memread};
    end
  end

  // Controller state reflects what happened on the previous cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RUN;
    end else begin
      if (if_flush)      state <= ST_FLUSH;
      else if (id_stall) state <= ST_STALL;
      else               state <= ST_RUN;
    end
  end

  // Free-running performance counters; wrap naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (id_stall) stall_cnt <= stall_cnt + 32'd1;
      if (if_flush) flush_cnt <= flush_cnt + 32'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22040127_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_22040127_hazard_ctrl
// Description : Directed scoreboard bench for the hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_22040127_hazard_ctrl;

  localparam logic [1:0] RUN = 2'b00, STL = 2'b01, FLS = 2'b10;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_use_rs1, id_use_rs2, id_reg_wen, id_memread;
  logic        id_branch, id_branch_taken, pipe_adv;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_stall, if_flush;
  logic [1:0]  fwd_sel1, fwd_sel2, ctrl_state;
  logic [31:0] stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       tag;
    logic        stall;
    logic [1:0]  f1;
    logic [1:0]  f2;
    logic        flush;
    logic [1:0]  st;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t q[$];
  exp_t e;

  ysyx_22040127_hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_wen(id_reg_wen), .id_memread(id_memread), .id_branch(id_branch),
    .id_branch_taken(id_branch_taken), .pipe_adv(pipe_adv), .id_stall(id_stall),
    .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .if_flush(if_flush),
    .ctrl_state(ctrl_state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Compare the oldest pending expectation against the DUT away from posedge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      check({e.tag, ".stall"}, 32'(id_stall),   32'(e.stall));
      check({e.tag, ".fwd1"},  32'(fwd_sel1),   32'(e.f1));
      check({e.tag, ".fwd2"},  32'(fwd_sel2),   32'(e.f2));
      check({e.tag, ".flush"}, 32'(if_flush),   32'(e.flush));
      check({e.tag, ".state"}, 32'(ctrl_state), 32'(e.st));
      check({e.tag, ".scnt"},  stall_cnt,       e.sc);
      check({e.tag, ".fcnt"},  flush_cnt,       e.fc);
    end
  end

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                        input logic wen, input logic mr, input logic br,
                        input logic tk, input logic adv);
    id_valid = v;  id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    id_rd = rd; id_reg_wen = wen; id_memread = mr; id_branch = br;
    id_branch_taken = tk; pipe_adv = adv;
  endtask

  task automatic push_exp(input string tag, input logic s, input logic [1:0] f1,
                          input logic [1:0] f2, input logic fl, input logic [1:0] st,
                          input logic [31:0] sc, input logic [31:0] fc);
    exp_t x;
    x.tag = tag; x.stall = s; x.f1 = f1; x.f2 = f2; x.flush = fl;
    x.st = st; x.sc = sc; x.fc = fc;
    q.push_back(x);
  endtask

  // Inputs are already applied; queue expectation, let it be checked, advance.
  task automatic step(input string tag, input logic s, input logic [1:0] f1,
                      input logic [1:0] f2, input logic fl, input logic [1:0] st,
                      input logic [31:0] sc, input logic [31:0] fc);
    push_exp(tag, s, f1, f2, fl, st, sc, fc);
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    set_id(1, 5'd5, 1, 5'd7, 1, 5'd0, 0, 0, 1, 1, 1);
    @(posedge clk); #1;
    // Inside reset: no hazards, idle state, counters zero.
    check("in_rst.stall", 32'(id_stall), 32'd0);
    check("in_rst.fwd1", 32'(fwd_sel1), 32'd0);
    check("in_rst.state", 32'(ctrl_state), 32'(RUN));
    check("in_rst.scnt", stall_cnt, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    set_id(1, 5'd5, 1, 5'd0, 0, 5'd0, 0, 0, 0, 0, 1);
    step("rst_out", 0, 2'b00, 2'b00, 0, RUN, 0, 0);

    // ALU-to-ALU forwarding walks 01 -> 10 -> 11 -> 00
    set_id(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 0, 0, 0, 1); step("A0", 0, 2'b00, 2'b00, 0, RUN, 0, 0);
    set_id(1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 0, 0, 1); step("A1", 0, 2'b01, 2'b00, 0, RUN, 0, 0);
    set_id(1, 5'd5, 1, 5'd0, 0, 5'd0, 0, 0, 0, 0, 1); step("A2", 0, 2'b10, 2'b00, 0, RUN, 0, 0);
    set_id(1, 5'd5, 1, 5'd0, 0, 5'd0, 0, 0, 0, 0, 1); step("A3", 0, 2'b11, 2'b00, 0, RUN, 0, 0);
    set_id(1, 5'd5, 1, 5'd6, 1, 5'd0, 0, 0, 0, 0, 1); step("A4", 0, 2'b00, 2'b11, 0, RUN, 0, 0);

    // Load-use: one stall cycle, then forward from MEM
    set_id(1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 1, 0, 0, 1); step("B0", 0, 2'b00, 2'b00, 0, RUN, 0, 0);
    set_id(1, 5'd0, 0, 5'd7, 1, 5'd8, 1, 0, 0, 0, 1); step("B1", 1, 2'b00, 2'b01, 0, RUN, 0, 0);
    step("B2", 0, 2'b00, 2'b10, 0, STL, 1, 0);
    set_id(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 1); step("B3", 0, 2'b00, 2'b00, 0, RUN, 1, 0);

    // Branch on load: two stalls, then WB forward and taken flush
    set_id(1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 1, 0, 0, 1); step("C0", 0, 2'b00, 2'b00, 0, RUN, 1, 0);
    set_id(1, 5'd7, 1, 5'd9, 1, 5'd0, 0, 0, 1, 1, 1); step("C1", 1, 2'b01, 2'b00, 0, RUN, 1, 0);
    step("C2", 1, 2'b10, 2'b00, 0, STL, 2, 0);
    step("C3", 0, 2'b11, 2'b00, 1, STL, 3, 0);
    set_id(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 1); step("C4", 0, 2'b00, 2'b00, 0, FLS, 3, 1);
    step("C5", 0, 2'b00, 2'b00, 0, RUN, 3, 1);

    // x0 never forwards; youngest writer wins; invalid ID reads regfile
    set_id(1, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 0, 0, 1); step("D0", 0, 2'b00, 2'b00, 0, RUN, 3, 1);
    set_id(1, 5'd0, 1, 5'd0, 0, 5'd3, 1, 0, 0, 0, 1); step("D1_x0", 0, 2'b00, 2'b00, 0, RUN, 3, 1);
    set_id(1, 5'd0, 0, 5'd0, 0, 5'd4, 1, 0, 0, 0, 1); step("D2", 0, 2'b00, 2'b00, 0, RUN, 3, 1);
    set_id(1, 5'd3, 1, 5'd4, 1, 5'd3, 1, 0, 0, 0, 1); step("D3", 0, 2'b10, 2'b01, 0, RUN, 3, 1);
    set_id(1, 5'd3, 1, 5'd3, 1, 5'd0, 0, 0, 0, 0, 1); step("D4_prio", 0, 2'b01, 2'b01, 0, RUN, 3, 1);
    set_id(0, 5'd3, 1, 5'd3, 1, 5'd0, 0, 0, 0, 0, 1); step("D5_inv", 0, 2'b00, 2'b00, 0, RUN, 3, 1);

    // Frozen pipe: stall persists and is counted every cycle
    set_id(1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 1, 0, 0, 1); step("E0", 0, 2'b00, 2'b00, 0, RUN, 3, 1);
    set_id(1, 5'd7, 1, 5'd0, 0, 5'd8, 1, 0, 0, 0, 0); step("E1", 1, 2'b01, 2'b00, 0, RUN, 3, 1);
    step("E2", 1, 2'b01, 2'b00, 0, STL, 4, 1);
    step("E3", 1, 2'b01, 2'b00, 0, STL, 5, 1);
    pipe_adv = 1'b1;                            step("E4", 1, 2'b01, 2'b00, 0, STL, 6, 1);
    step("E5", 0, 2'b10, 2'b00, 0, STL, 7, 1);
    // Taken branch waits for pipe_adv before squashing IF
    set_id(1, 5'd7, 1, 5'd0, 0, 5'd0, 0, 0, 1, 1, 0); step("E6_noadv", 0, 2'b11, 2'b00, 0, RUN, 7, 1);
    pipe_adv = 1'b1;                            step("E7", 0, 2'b11, 2'b00, 1, RUN, 7, 1);

    // Mid-stream reset clears everything within the same cycle
    set_id(1, 5'd7, 1, 5'd8, 1, 5'd9, 1, 0, 0, 0, 1);
    push_exp("E8", 0, 2'b00, 2'b10, 0, FLS, 7, 2);
    @(negedge clk); #2;
    rst = 1'b1; #1;
    check("mid_rst.stall", 32'(id_stall), 32'd0);
    check("mid_rst.fwd1", 32'(fwd_sel1), 32'd0);
    check("mid_rst.fwd2", 32'(fwd_sel2), 32'd0);
    check("mid_rst.state", 32'(ctrl_state), 32'(RUN));
    check("mid_rst.scnt", stall_cnt, 32'd0);
    check("mid_rst.fcnt", flush_cnt, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    step("R0", 0, 2'b00, 2'b00, 0, RUN, 0, 0);
    set_id(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 1); step("R1", 0, 2'b00, 2'b00, 0, RUN, 0, 0);

    check("queue_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
